// File: rtl/hog_cell_accum.sv
// HOG cell accumulator: sums four per-pixel bin vectors per beat and folds
// CELL_ROWS rows per column into one saturated cell histogram.
module hog_cell_accum #(
   parameter int NBINS     = 9,
   parameter int BIN_W     = 16,
   parameter int ACC_W     = 20,
   parameter int NUM_COLS  = 53,
   parameter int CELL_ROWS = 4,
   parameter int NUM_ROWS  = 160
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [7:0]             cnt_row,
   input  logic [5:0]             cnt_col,
   input  logic [NBINS*BIN_W-1:0] hog_in0,
   input  logic [NBINS*BIN_W-1:0] hog_in1,
   input  logic [NBINS*BIN_W-1:0] hog_in2,
   input  logic [NBINS*BIN_W-1:0] hog_in3,
   output logic                   out_valid,
   output logic [NBINS*ACC_W-1:0] hist_out,
   output logic [5:0]             out_cell_row,
   output logic [5:0]             out_cell_col,
   output logic                   frame_done,
   output logic                   sat_flag,
   output logic                   col_err
);

   localparam int SUM_W = BIN_W + 2;
   localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
   localparam logic [EXT_W-1:0] ACC_MAX = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

   logic [NBINS*ACC_W-1:0] entry_q [NUM_COLS];

   logic                   col_ok;
   logic                   first_row;
   logic                   last_row;
   logic                   any_sat;
   logic [31:0]            phase;
   logic [5:0]             cell_row;
   logic [NBINS*ACC_W-1:0] cur_entry;
   logic [NBINS*ACC_W-1:0] next_sum;
   logic [SUM_W-1:0]       beat_sum [NBINS];
   logic [ACC_W-1:0]       base_val [NBINS];
   logic [EXT_W-1:0]       wide_sum [NBINS];

   // Whole read-modify-write is combinational so back-to-back beats on one column see fresh data.
   always_comb begin
      col_ok    = 32'(cnt_col) < 32'(NUM_COLS);
      phase     = 32'(cnt_row) % 32'(CELL_ROWS);
      first_row = (phase == 32'd0);
      last_row  = (phase == 32'(CELL_ROWS - 1));
      cell_row  = 6'(32'(cnt_row) / 32'(CELL_ROWS));
      cur_entry = col_ok ? entry_q[cnt_col] : '0;
      any_sat   = 1'b0;
      next_sum  = '0;
      for (int k = 0; k < NBINS; k++) begin
         beat_sum[k] = SUM_W'(hog_in0[k*BIN_W +: BIN_W]) + SUM_W'(hog_in1[k*BIN_W +: BIN_W])
                     + SUM_W'(hog_in2[k*BIN_W +: BIN_W]) + SUM_W'(hog_in3[k*BIN_W +: BIN_W]);
         base_val[k] = first_row ? '0 : cur_entry[k*ACC_W +: ACC_W];
         wide_sum[k] = EXT_W'(base_val[k]) + EXT_W'(beat_sum[k]);
         if (wide_sum[k] > ACC_MAX) begin
            next_sum[k*ACC_W +: ACC_W] = '1;
            any_sat = 1'b1;
         end else begin
            next_sum[k*ACC_W +: ACC_W] = ACC_W'(wide_sum[k]);
         end
      end
   end

   // One register bank per column; the last row of a cell leaves the entry cleared.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            entry_q[c] <= '0;
         end else if (in_valid && col_ok && (cnt_col == 6'(c))) begin
            entry_q[c] <= last_row ? '0 : next_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         hist_out     <= '0;
         out_cell_row <= '0;
         out_cell_col <= '0;
         frame_done   <= 1'b0;
         sat_flag     <= 1'b0;
         col_err      <= 1'b0;
      end else begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (in_valid && !col_ok) begin
            col_err <= 1'b1;
         end
         if (in_valid && col_ok) begin
            if (any_sat) begin
               sat_flag <= 1'b1;
            end
            if (last_row) begin
               out_valid    <= 1'b1;
               hist_out     <= next_sum;
               out_cell_row <= cell_row;
               out_cell_col <= cnt_col;
               frame_done   <= (cnt_row == 8'(NUM_ROWS - 1)) && (cnt_col == 6'(NUM_COLS - 1));
            end
         end
      end
   end

endmodule

// File: tb/tb_hog_cell_accum.sv
// Directed bench for hog_cell_accum: a bin-level model pushes expected cells to a
// scoreboard queue that is popped on every out_valid.
module tb_hog_cell_accum;

   localparam int NBINS     = 9;
   localparam int BIN_W     = 16;
   localparam int ACC_W     = 20;
   localparam int NUM_COLS  = 53;
   localparam int CELL_ROWS = 4;
   localparam int NUM_ROWS  = 160;
   localparam int SMALL_W   = 18;
   localparam int DW        = NBINS * BIN_W;
   localparam int HW        = NBINS * ACC_W;
   localparam int SHW       = NBINS * SMALL_W;
   localparam int ACC_MAX   = (1 << ACC_W) - 1;

   typedef struct {
      logic [HW-1:0] hist;
      logic [5:0]    row;
      logic [5:0]    col;
      logic          frame;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_valid_small;
   logic          use_small;
   logic [7:0]    cnt_row;
   logic [5:0]    cnt_col;
   logic [DW-1:0] hog_in0, hog_in1, hog_in2, hog_in3;
   logic          out_valid, frame_done, sat_flag, col_err;
   logic [HW-1:0] hist_out;
   logic [5:0]    out_cell_row, out_cell_col;
   logic          small_valid, small_frame, small_sat, small_col_err;
   logic [SHW-1:0] small_hist;
   logic [5:0]    small_row, small_col;

   int            checks = 0;
   int            errors = 0;
   int            pulses = 0;
   exp_t          sb[$];
   int            model [NUM_COLS][NBINS];
   logic          model_sat;
   logic          model_col_err;
   logic [HW-1:0] last_hist;

   always #5 clk = ~clk;

   assign in_valid_small = in_valid && use_small;

   hog_cell_accum #(.NBINS(NBINS), .BIN_W(BIN_W), .ACC_W(ACC_W), .NUM_COLS(NUM_COLS),
                    .CELL_ROWS(CELL_ROWS), .NUM_ROWS(NUM_ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .cnt_row(cnt_row), .cnt_col(cnt_col),
      .hog_in0(hog_in0), .hog_in1(hog_in1), .hog_in2(hog_in2), .hog_in3(hog_in3),
      .out_valid(out_valid), .hist_out(hist_out), .out_cell_row(out_cell_row),
      .out_cell_col(out_cell_col), .frame_done(frame_done), .sat_flag(sat_flag),
      .col_err(col_err));

   // Narrow accumulators make saturation reachable within a single 4-row cell.
   hog_cell_accum #(.NBINS(NBINS), .BIN_W(BIN_W), .ACC_W(SMALL_W), .NUM_COLS(NUM_COLS),
                    .CELL_ROWS(CELL_ROWS), .NUM_ROWS(NUM_ROWS)) dut_small (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_small), .cnt_row(cnt_row), .cnt_col(cnt_col),
      .hog_in0(hog_in0), .hog_in1(hog_in1), .hog_in2(hog_in2), .hog_in3(hog_in3),
      .out_valid(small_valid), .hist_out(small_hist), .out_cell_row(small_row),
      .out_cell_col(small_col), .frame_done(small_frame), .sat_flag(small_sat),
      .col_err(small_col_err));

   function automatic logic [DW-1:0] fill_in(input int v);
      logic [DW-1:0] r;
      for (int k = 0; k < NBINS; k++) r[k*BIN_W +: BIN_W] = BIN_W'(v);
      return r;
   endfunction

   function automatic logic [HW-1:0] fill_acc(input int v);
      logic [HW-1:0] r;
      for (int k = 0; k < NBINS; k++) r[k*ACC_W +: ACC_W] = ACC_W'(v);
      return r;
   endfunction

   function automatic logic [SHW-1:0] fill_small(input int v);
      logic [SHW-1:0] r;
      for (int k = 0; k < NBINS; k++) r[k*SMALL_W +: SMALL_W] = SMALL_W'(v);
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic clear_model();
      for (int c = 0; c < NUM_COLS; c++)
         for (int k = 0; k < NBINS; k++) model[c][k] = 0;
      model_sat     = 1'b0;
      model_col_err = 1'b0;
      sb.delete();
   endtask

   // Behavioural model of one beat, derived from the bin arithmetic alone.
   task automatic model_beat(input int row, input int col, input logic [DW-1:0] d0,
                             input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                             input logic [DW-1:0] d3);
      exp_t e;
      int   ph, v;
      if (col >= NUM_COLS) begin
         model_col_err = 1'b1;
         return;
      end
      ph = row % CELL_ROWS;
      e.hist = '0;
      for (int k = 0; k < NBINS; k++) begin
         v = ((ph == 0) ? 0 : model[col][k]) + int'(d0[k*BIN_W +: BIN_W]) + int'(d1[k*BIN_W +: BIN_W])
           + int'(d2[k*BIN_W +: BIN_W]) + int'(d3[k*BIN_W +: BIN_W]);
         if (v > ACC_MAX) begin
            v = ACC_MAX;
            model_sat = 1'b1;
         end
         e.hist[k*ACC_W +: ACC_W] = ACC_W'(v);
         model[col][k] = (ph == CELL_ROWS - 1) ? 0 : v;
      end
      if (ph == CELL_ROWS - 1) begin
         e.row   = 6'(row / CELL_ROWS);
         e.col   = 6'(col);
         e.frame = (row == NUM_ROWS - 1) && (col == NUM_COLS - 1);
         sb.push_back(e);
      end
   endtask

   task automatic check_output();
      exp_t e;
      check_eq("out_valid", out_valid, sb.size() != 0);
      if (out_valid && sb.size() != 0) begin
         e = sb.pop_front();
         pulses++;
         last_hist = e.hist;
         check_eq("hist_out", hist_out, e.hist);
         check_eq("out_cell_row", out_cell_row, e.row);
         check_eq("out_cell_col", out_cell_col, e.col);
         check_eq("frame_done", frame_done, e.frame);
      end else begin
         check_eq("frame_done_idle", frame_done, 1'b0);
         sb.delete();
      end
      check_eq("sat_flag", sat_flag, model_sat);
      check_eq("col_err", col_err, model_col_err);
   endtask

   task automatic apply_stimulus(input logic v, input int row, input int col,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] d2, input logic [DW-1:0] d3);
      in_valid = v;
      cnt_row  = 8'(row);
      cnt_col  = 6'(col);
      hog_in0  = d0;
      hog_in1  = d1;
      hog_in2  = d2;
      hog_in3  = d3;
      if (v) model_beat(row, col, d0, d1, d2, d3);
      @(posedge clk);
      #1;
      check_output();
      in_valid = 1'b0;
   endtask

   task automatic apply_reset(input int cycles);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      clear_model();
      check_output();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; use_small = 1'b0;
      cnt_row = '0; cnt_col = '0;
      hog_in0 = '0; hog_in1 = '0; hog_in2 = '0; hog_in3 = '0;
      last_hist = '0;

      apply_reset(2);
      check_eq("reset_hist", hist_out, '0);
      check_eq("reset_row", out_cell_row, '0);
      check_eq("reset_col", out_cell_col, '0);

      for (int r = 0; r < 4; r++) apply_stimulus(1'b1, r, 5, fill_in(1), fill_in(1), fill_in(1), fill_in(1));
      check_eq("uniform_hist", hist_out, fill_acc(16));
      check_eq("uniform_row", out_cell_row, 6'd0);
      check_eq("uniform_col", out_cell_col, 6'd5);

      for (int r = 0; r < 4; r++) begin
         if (r == 3) pulses = 0;
         for (int c = 0; c < NUM_COLS; c++) apply_stimulus(1'b1, r, c, fill_in(c), '0, '0, '0);
      end
      check_eq("interleave_pulses", pulses, 53);
      check_eq("interleave_col52", hist_out, fill_acc(4 * 52));

      use_small = 1'b1;
      for (int r = 0; r < 4; r++)
         apply_stimulus(1'b1, r, 0, fill_in(16'hFFFF), fill_in(16'hFFFF), fill_in(16'hFFFF), fill_in(16'hFFFF));
      check_eq("sat_main_hist", hist_out, fill_acc(20'hFFFF0));
      check_eq("sat_main_flag", sat_flag, 1'b0);
      check_eq("sat_small_valid", small_valid, 1'b1);
      check_eq("sat_small_hist", small_hist, fill_small(18'h3FFFF));
      check_eq("sat_small_flag", small_sat, 1'b1);
      for (int r = 4; r < 8; r++) apply_stimulus(1'b1, r, 0, fill_in(1), fill_in(1), fill_in(1), fill_in(1));
      check_eq("clean_small_hist", small_hist, fill_small(16));
      check_eq("clean_small_row", small_row, 6'd1);
      check_eq("clean_small_col", small_col, 6'd0);
      check_eq("clean_small_sticky", small_sat, 1'b1);
      check_eq("clean_small_colerr", small_col_err, 1'b0);
      check_eq("clean_small_frame", small_frame, 1'b0);
      use_small = 1'b0;

      apply_stimulus(1'b1, 159, 52, fill_in(1), fill_in(1), fill_in(1), fill_in(1));
      check_eq("frame_done_end", frame_done, 1'b1);
      check_eq("frame_cell_row", out_cell_row, 6'd39);
      check_eq("frame_hist", hist_out, fill_acc(4));

      for (int r = 0; r < 2; r++) apply_stimulus(1'b1, r, 10, fill_in(1), fill_in(1), fill_in(1), fill_in(1));
      apply_stimulus(1'b1, 3, 60, fill_in(9), fill_in(9), fill_in(9), fill_in(9));
      check_eq("badcol_err", col_err, 1'b1);
      check_eq("badcol_no_valid", out_valid, 1'b0);
      for (int r = 2; r < 4; r++) apply_stimulus(1'b1, r, 10, fill_in(1), fill_in(1), fill_in(1), fill_in(1));
      check_eq("badcol_next_hist", hist_out, fill_acc(16));

      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 3, 10, fill_in(7), fill_in(7), fill_in(7), fill_in(7));
      check_eq("idle_hold_hist", hist_out, last_hist);
      check_eq("idle_hold_col", out_cell_col, 6'd10);

      for (int r = 0; r < 2; r++) apply_stimulus(1'b1, r, 7, fill_in(5), fill_in(5), fill_in(5), fill_in(5));
      apply_reset(1);
      for (int r = 2; r < 4; r++) apply_stimulus(1'b1, r, 7, fill_in(2), fill_in(2), fill_in(2), fill_in(2));
      check_eq("midreset_hist", hist_out, fill_acc(16));
      check_eq("midreset_col", out_cell_col, 6'd7);

      check_eq("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
